axi_mem_slave: RTL and testbench

Memory-backed burst slave sitting directly downstream of the team's bus master, terminating its read (AR/R) and write (AW/W/B) channels. Holds a DEPTH x 8-bit dual-port memory; read and write channels run as independent state machines so one read burst and one write burst can be in flight simultaneously. Returns per-beat read status and per-burst write status in the packed formats the master already consumes.

---
 rtl/axi_slv_pkg.sv | 73 +++++++
 rtl/axi_slv_mem.sv | 50 +++++
 rtl/axi_mem_slave.sv | 228 ++++++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slv_pkg.sv
// Shared field map, state encodings and packing helpers for axi_mem_slave.
// Build option: define AXI_SLV_ERR_EN to report read-wrap and write-overflow errors.
package axi_slv_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;
  localparam int ID_W   = 4;
  localparam int BEAT_W = 5;

  // ARIN: [15:8] start address, [7:4] length-1, [3:0] ID
  localparam int ARIN_W      = 16;
  localparam int AR_ADDR_LSB = 8;
  localparam int AR_LEN_LSB  = 4;
  localparam int AR_ID_LSB   = 0;

  // AWIN: [11:4] start address, [3:0] ID
  localparam int AWIN_W      = 12;
  localparam int AW_ADDR_LSB = 4;
  localparam int AW_ID_LSB   = 0;

  // ROUT: [8:1] data, [0] beat response
  localparam int ROUT_W        = 9;
  localparam int ROUT_DATA_LSB = 1;
  localparam int ROUT_RESP_BIT = 0;

  // BRESP: [4:1] echoed ID, [0] error
  localparam int BRESP_W        = 5;
  localparam int BRESP_ID_LSB   = 1;
  localparam int BRESP_ERR_BIT  = 0;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  function automatic logic [ROUT_W-1:0] pack_rout(input logic [DATA_W-1:0] data,
                                                  input logic              err);
    return {data, err};
  endfunction

  function automatic logic [BRESP_W-1:0] pack_bresp(input logic [ID_W-1:0] id,
                                                    input logic            err);
    return {id, err};
  endfunction

  // True when the address is the top word of a DEPTH-word memory.
  function automatic logic addr_is_last(input logic [ADDR_W-1:0] a, input int depth);
    return (a == ADDR_W'(depth - 1));
  endfunction

  // Next address, wrapping modulo DEPTH.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a, input int depth);
    logic [ADDR_W-1:0] n;
    if (addr_is_last(a, depth)) begin
      n = {ADDR_W{1'b0}};
    end else begin
      n = a + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
    return n;
  endfunction

endpackage

// File: rtl/axi_slv_mem.sv
// DEPTH x 8 dual-port RAM: one registered read port, one write port.
// A read and a write to the same word on the same edge return the old contents.
module axi_slv_mem
  import axi_slv_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  // Storage array: written on the write port, contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read data register: fetch on rd_en, otherwise hold the last fetched word.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Read data flop; clearing it keeps the read output quiet out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= {DATA_W{1'b0}};
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_mem_slave.sv
// Memory-backed burst slave with independent read (AR/R) and write (AW/W/B) FSMs.
// Build option: AXI_SLV_ERR_EN enables the read-wrap and write-overflow error bits;
// without it ROUT[0] and BRESP[0] stay 0 while wrap and beat dropping still apply.
module axi_mem_slave
  import axi_slv_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int MAX_BEATS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ARVALID,
  input  logic [ARIN_W-1:0]   ARIN,
  output logic                ARREADY,
  output logic                RVALID,
  input  logic                RREADY,
  output logic [ROUT_W-1:0]   ROUT,
  output logic                RLAST,
  input  logic                AWVALID,
  input  logic [AWIN_W-1:0]   AWIN,
  output logic                AWREADY,
  input  logic                WVALID,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic                WLAST,
  output logic                WREADY,
  output logic                BVALID,
  input  logic                BREADY,
  output logic [BRESP_W-1:0]  BRESP
);

`ifdef AXI_SLV_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  // Read channel state
  r_state_e          r_state_q, r_state_d;
  logic [ADDR_W-1:0] r_addr_q,  r_addr_d;
  logic [LEN_W-1:0]  r_len_q,   r_len_d;
  logic [LEN_W-1:0]  r_beat_q,  r_beat_d;
  logic              r_wrap_q,  r_wrap_d;

  // Write channel state
  w_state_e          w_state_q, w_state_d;
  logic [ADDR_W-1:0] w_addr_q,  w_addr_d;
  logic [ID_W-1:0]   w_id_q,    w_id_d;
  logic [BEAT_W-1:0] w_beat_q,  w_beat_d;
  logic              w_err_q,   w_err_d;

  // RAM port signals
  logic              rd_en_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [DATA_W-1:0] rd_data_s;
  logic              wr_en_s;
  logic              r_err_s;
  logic              w_err_s;

  // The read ID is accepted but the packed R format has no field for it.
  logic unused_ar_id_s;
  assign unused_ar_id_s = ^ARIN[AR_ID_LSB +: ID_W];

  axi_slv_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en_s),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s),
    .wr_en   (wr_en_s),
    .wr_addr (w_addr_q),
    .wr_data (WDATA)
  );

  // Read FSM next state: fetch the first word, then prefetch the next word
  // on every non-final handshake so beats can stream back to back.
  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_wrap_d  = r_wrap_q;
    rd_en_s   = 1'b0;
    rd_addr_s = r_addr_q;
    case (r_state_q)
      R_IDLE: begin
        if (ARVALID) begin
          r_addr_d  = ARIN[AR_ADDR_LSB +: ADDR_W];
          r_len_d   = ARIN[AR_LEN_LSB +: LEN_W];
          r_beat_d  = {LEN_W{1'b0}};
          r_wrap_d  = 1'b0;
          r_state_d = R_ADDR;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_ADDR: begin
        rd_en_s   = 1'b1;
        rd_addr_s = r_addr_q;
        r_state_d = R_DATA;
      end
      R_DATA: begin
        if (RREADY) begin
          if (r_beat_q == r_len_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_beat_d  = r_beat_q + {{(LEN_W-1){1'b0}}, 1'b1};
            r_addr_d  = addr_inc(r_addr_q, DEPTH);
            rd_en_s   = 1'b1;
            rd_addr_s = addr_inc(r_addr_q, DEPTH);
            if (addr_is_last(r_addr_q, DEPTH)) begin
              r_wrap_d = 1'b1;
            end else begin
              r_wrap_d = r_wrap_q;
            end
          end
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: begin
        r_state_d = R_IDLE;
      end
    endcase
  end

  // Read channel registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= {ADDR_W{1'b0}};
      r_len_q   <= {LEN_W{1'b0}};
      r_beat_q  <= {LEN_W{1'b0}};
      r_wrap_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_wrap_q  <= r_wrap_d;
    end
  end

  // Write FSM next state: commit beats up to MAX_BEATS, drop and flag the rest.
  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_id_d    = w_id_q;
    w_beat_d  = w_beat_q;
    w_err_d   = w_err_q;
    wr_en_s   = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (AWVALID) begin
          w_addr_d  = AWIN[AW_ADDR_LSB +: ADDR_W];
          w_id_d    = AWIN[AW_ID_LSB +: ID_W];
          w_beat_d  = {BEAT_W{1'b0}};
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_DATA: begin
        if (WVALID) begin
          if (w_beat_q < BEAT_W'(MAX_BEATS)) begin
            wr_en_s  = 1'b1;
            w_addr_d = addr_inc(w_addr_q, DEPTH);
            w_beat_d = w_beat_q + {{(BEAT_W-1){1'b0}}, 1'b1};
          end else begin
            w_err_d  = 1'b1;
          end
          if (WLAST) begin
            w_state_d = W_RESP;
          end else begin
            w_state_d = W_DATA;
          end
        end else begin
          w_state_d = W_DATA;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          w_err_d   = 1'b0;
          w_state_d = W_IDLE;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: begin
        w_state_d = W_IDLE;
      end
    endcase
  end

  // Write channel registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= {ADDR_W{1'b0}};
      w_id_q    <= {ID_W{1'b0}};
      w_beat_q  <= {BEAT_W{1'b0}};
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_id_q    <= w_id_d;
      w_beat_q  <= w_beat_d;
      w_err_q   <= w_err_d;
    end
  end

  // Outputs decode only from flops, so they never depend on same-cycle inputs.
  assign r_err_s = r_wrap_q & ERR_EN;
  assign w_err_s = w_err_q & ERR_EN;

  assign ARREADY = (r_state_q == R_IDLE);
  assign RVALID  = (r_state_q == R_DATA);
  assign RLAST   = (r_state_q == R_DATA) && (r_beat_q == r_len_q);
  assign ROUT    = (r_state_q == R_DATA) ? pack_rout(rd_data_s, r_err_s) : {ROUT_W{1'b0}};

  assign AWREADY = (w_state_q == W_IDLE);
  assign WREADY  = (w_state_q == W_DATA);
  assign BVALID  = (w_state_q == W_RESP);
  assign BRESP   = (w_state_q == W_RESP) ? pack_bresp(w_id_q, w_err_s) : {BRESP_W{1'b0}};

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed self-checking bench for axi_mem_slave.
// Expected error bits follow AXI_SLV_ERR_EN when it is defined for the build.
module tb_axi_mem_slave;

`ifdef AXI_SLV_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif
  localparam int TMO = 50;

  logic        clk;
  logic        rst;
  logic        ARVALID;
  logic [15:0] ARIN;
  logic        ARREADY;
  logic        RVALID;
  logic        RREADY;
  logic [8:0]  ROUT;
  logic        RLAST;
  logic        AWVALID;
  logic [11:0] AWIN;
  logic        AWREADY;
  logic        WVALID;
  logic [7:0]  WDATA;
  logic        WLAST;
  logic        WREADY;
  logic        BVALID;
  logic        BREADY;
  logic [4:0]  BRESP;

  int total = 0;
  int bad   = 0;

  logic [7:0] wbuf [32];
  logic [7:0] rexp [16];
  logic       rerr [16];

  axi_mem_slave dut (
    .clk     (clk),
    .rst     (rst),
    .ARVALID (ARVALID),
    .ARIN    (ARIN),
    .ARREADY (ARREADY),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .ROUT    (ROUT),
    .RLAST   (RLAST),
    .AWVALID (AWVALID),
    .AWIN    (AWIN),
    .AWREADY (AWREADY),
    .WVALID  (WVALID),
    .WDATA   (WDATA),
    .WLAST   (WLAST),
    .WREADY  (WREADY),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .BRESP   (BRESP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Write burst of n beats from wbuf; checks B timing, response and AWREADY return.
  task automatic do_write(input string tag, input logic [7:0] a, input logic [3:0] id,
                          input int n, input logic [4:0] exp_b);
    int t;
    @(negedge clk);
    AWIN = {a, id};
    AWVALID = 1'b1;
    t = 0;
    while (!AWREADY && t < TMO) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_aw_timeout"}, 32'(t < TMO), 32'd1);
    @(negedge clk);
    AWVALID = 1'b0;
    chk({tag, "_wready"}, {31'd0, WREADY}, 32'd1);
    for (int i = 0; i < n; i++) begin
      WDATA  = wbuf[i];
      WLAST  = (i == n - 1);
      WVALID = 1'b1;
      t = 0;
      while (!WREADY && t < TMO) begin
        @(negedge clk);
        t++;
      end
      @(negedge clk);
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
    chk({tag, "_bvalid"}, {30'd0, BVALID, WREADY}, 32'd2);
    chk({tag, "_bresp"}, {27'd0, BRESP}, {27'd0, exp_b});
    BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    chk({tag, "_aw_again"}, {30'd0, AWREADY, BVALID}, 32'd2);
  endtask

  // Read burst checked against rexp/rerr; optionally stalls 3 cycles on one beat.
  task automatic do_read(input string tag, input logic [7:0] a, input logic [3:0] len,
                         input int stall_beat);
    int t;
    logic [8:0] hold_rout;
    logic       hold_last;
    @(negedge clk);
    ARIN = {a, len, 4'h6};
    ARVALID = 1'b1;
    t = 0;
    while (!ARREADY && t < TMO) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_ar_timeout"}, 32'(t < TMO), 32'd1);
    @(negedge clk);
    ARVALID = 1'b0;
    chk({tag, "_fetch"}, {30'd0, ARREADY, RVALID}, 32'd0);
    @(negedge clk);
    for (int b = 0; b <= int'(len); b++) begin
      chk({tag, "_rvalid"}, {31'd0, RVALID}, 32'd1);
      if (b == stall_beat) begin
        hold_rout = ROUT;
        hold_last = RLAST;
        repeat (3) begin
          @(negedge clk);
          chk({tag, "_stall"}, {21'd0, RVALID, RLAST, ROUT}, {21'd0, 1'b1, hold_last, hold_rout});
        end
      end
      chk({tag, "_data"}, {24'd0, ROUT[8:1]}, {24'd0, rexp[b]});
      chk({tag, "_err"}, {31'd0, ROUT[0]}, {31'd0, rerr[b]});
      chk({tag, "_rlast"}, {31'd0, RLAST}, 32'(b == int'(len)));
      RREADY = 1'b1;
      @(negedge clk);
      RREADY = 1'b0;
    end
    chk({tag, "_done"}, {30'd0, RVALID, ARREADY}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ARVALID = 1'b0; ARIN = 16'd0; RREADY = 1'b0;
    AWVALID = 1'b0; AWIN = 12'd0; WVALID = 1'b0; WDATA = 8'd0; WLAST = 1'b0;
    BREADY = 1'b0;
    for (int i = 0; i < 16; i++) rerr[i] = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {30'd0, ARREADY, AWREADY}, 32'd3);
    chk("rst_valid", {29'd0, RVALID, WREADY, BVALID}, 32'd0);
    chk("rst_rout", {22'd0, RLAST, ROUT}, 32'd0);
    chk("rst_bresp", {27'd0, BRESP}, 32'd0);
    rst = 1'b0;

    // Basic write then read back
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    do_write("w4", 8'h10, 4'h5, 4, 5'h0A);
    rexp[0] = 8'h11; rexp[1] = 8'h22; rexp[2] = 8'h33; rexp[3] = 8'h44;
    do_read("r4", 8'h10, 4'd3, -1);

    // Address wrap: write wraps silently, read flags beats past the top
    wbuf[0] = 8'hC1; wbuf[1] = 8'hC2; wbuf[2] = 8'hC3;
    do_write("wwrap", 8'hFE, 4'h1, 3, 5'h02);
    rexp[0] = 8'hC1; rexp[1] = 8'hC2; rexp[2] = 8'hC3;
    rerr[0] = 1'b0;  rerr[1] = 1'b0;  rerr[2] = ERR;
    do_read("rwrap", 8'hFE, 4'd2, -1);
    rerr[2] = 1'b0;

    // Overflow: 18 beats, the last two are dropped
    wbuf[0] = 8'h5A; wbuf[1] = 8'hA5;
    do_write("wpre30", 8'h30, 4'h4, 2, 5'h08);
    for (int i = 0; i < 18; i++) wbuf[i] = 8'(8'h80 + i);
    do_write("wovf", 8'h20, 4'h3, 18, {4'h3, ERR});
    for (int i = 0; i < 16; i++) rexp[i] = 8'(8'h80 + i);
    do_read("rovf", 8'h20, 4'd15, -1);
    rexp[0] = 8'h5A; rexp[1] = 8'hA5;
    do_read("r30", 8'h30, 4'd1, -1);

    // Back-pressure on the third beat
    rexp[0] = 8'h11; rexp[1] = 8'h22; rexp[2] = 8'h33; rexp[3] = 8'h44;
    do_read("rstall", 8'h10, 4'd3, 2);

    // Concurrent bursts on the same words: each read sees the pre-write value
    wbuf[0] = 8'hA0; wbuf[1] = 8'hA1; wbuf[2] = 8'hA2; wbuf[3] = 8'hA3;
    do_write("wpre40", 8'h40, 4'h7, 4, 5'h0E);
    wbuf[0] = 8'hB0; wbuf[1] = 8'hB1; wbuf[2] = 8'hB2; wbuf[3] = 8'hB3;
    rexp[0] = 8'hA0; rexp[1] = 8'hA1; rexp[2] = 8'hA2; rexp[3] = 8'hA3;
    fork
      do_write("wcc", 8'h40, 4'h2, 4, 5'h04);
      do_read("rcc", 8'h40, 4'd3, -1);
    join
    rexp[0] = 8'hB0; rexp[1] = 8'hB1; rexp[2] = 8'hB2; rexp[3] = 8'hB3;
    do_read("rcc_after", 8'h40, 4'd3, -1);

    // Reset in the middle of a read burst and a write burst
    @(negedge clk);
    ARIN = {8'h20, 4'd15, 4'h0}; ARVALID = 1'b1;
    AWIN = {8'h50, 4'h9};        AWVALID = 1'b1;
    @(negedge clk);
    ARVALID = 1'b0; AWVALID = 1'b0;
    WDATA = 8'hEE; WLAST = 1'b0; WVALID = 1'b1;
    @(negedge clk);
    WVALID = 1'b0;
    @(negedge clk);
    chk("mid_busy", {30'd0, RVALID, WREADY}, 32'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", {30'd0, ARREADY, AWREADY}, 32'd3);
    chk("mid_rst_valid", {29'd0, RVALID, WREADY, BVALID}, 32'd0);
    @(negedge clk);
    chk("mid_rst_hold", {27'd0, ARREADY, AWREADY, RVALID, WREADY, BVALID}, 32'h18);
    rst = 1'b0;

    // Committed partial write survives; zero-length read gives one RLAST beat
    rexp[0] = 8'hEE;
    do_read("rlen0", 8'h50, 4'd0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
